// File: rtl/cu_pkg.sv
// Shared constants for the hardwired control unit and the DataPath ALU:
// state encoding, instruction opcodes and ALU function codes.
package cu_pkg;

   // Sequencer state encoding (also exported on the debug 'state' port)
   localparam logic [3:0] S_RST  = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_HALT = 4'd7;

   // Opcodes in ir[31:27]
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_HALT = 5'b11011;

   // ALU function select, shared with the DataPath ALU
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SHR = 4'd4;
   localparam logic [3:0] ALU_SHL = 4'd5;

   // True for the three-register ALU instructions
   function automatic logic is_alu_opcode(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
             (op == OP_OR)  || (op == OP_SHR) || (op == OP_SHL);
   endfunction

   // Opcode to ALU function; non-ALU opcodes fall back to ADD
   function automatic logic [3:0] alu_of_opcode(input logic [4:0] op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_SHR:  return ALU_SHR;
         OP_SHL:  return ALU_SHL;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/cu_reg_decode.sv
// Converts a 4-bit register field plus enable into a one-hot R0..R15 vector.
module cu_reg_decode
   import cu_pkg::*;
(
   input  logic [3:0]  field,
   input  logic        en,
   output logic [15:0] onehot
);

   // One comparator per register bit; all zero when not enabled
   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_bit
         assign onehot[gi] = en && (field == 4'(gi));
      end
   endgenerate

endmodule

// File: rtl/control_unit.sv
// Hardwired control unit: six-step fetch/execute sequencer for the
// three-register ALU instructions, with HALT and a sticky illegal flag.
// Optional feature macro CU_MEMWAIT_EN: T1 waits for mem_ready before
// leaving the fetch read cycle.
module control_unit
   import cu_pkg::*;
(
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic        PCout,
   output logic        Zlowout,
   output logic        MDRout,
   output logic        MARin,
   output logic        Zin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        IncPC,
   output logic        Read,
   output logic [3:0]  alu_op,
   output logic [15:0] Rout,
   output logic [15:0] Rin,
   output logic        run,
   output logic        illegal,
   output logic [3:0]  state
);

   logic [3:0] state_reg;
   logic [3:0] state_next;
   logic       illegal_reg;
   logic [4:0] opcode;
   logic       op_alu;
   logic       t1_exit;
   logic       rout_en;
   logic [3:0] rout_field;
   logic       rin_en;

   assign opcode = ir[31:27];
   assign op_alu = is_alu_opcode(opcode);

`ifdef CU_MEMWAIT_EN
   assign t1_exit = mem_ready;
   logic unused_ir;
   assign unused_ir = &{1'b0, ir[14:0]};
`else
   assign t1_exit = 1'b1;
   logic unused_in;
   assign unused_in = &{1'b0, mem_ready, ir[14:0]};
`endif

   // State register; clear forces RST at once
   always_ff @(posedge clock or posedge clear) begin
      if (clear) state_reg <= S_RST;
      else       state_reg <= state_next;
   end

   // Sticky illegal flag, raised when T3 decodes an undefined opcode
   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         illegal_reg <= 1'b0;
      else if (state_reg == S_T3 && !op_alu && opcode != OP_HALT)
         illegal_reg <= 1'b1;
   end

   // Next-state sequencing
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_RST:   state_next = S_T0;
         S_T0:    state_next = S_T1;
         S_T1:    state_next = t1_exit ? S_T2 : S_T1;
         S_T2:    state_next = S_T3;
         S_T3:    state_next = op_alu ? S_T4 : S_HALT;
         S_T4:    state_next = S_T5;
         S_T5:    state_next = S_T0;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_RST;
      endcase
   end

   // Moore output decode; only one bus source is ever selected per state
   always_comb begin
      PCout      = 1'b0;
      Zlowout    = 1'b0;
      MDRout     = 1'b0;
      MARin      = 1'b0;
      Zin        = 1'b0;
      PCin       = 1'b0;
      MDRin      = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      IncPC      = 1'b0;
      Read       = 1'b0;
      alu_op     = ALU_ADD;
      rout_en    = 1'b0;
      rout_field = ir[22:19];
      rin_en     = 1'b0;
      case (state_reg)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Read    = 1'b1;
            MDRin   = 1'b1;
            PCin    = t1_exit;
            Zlowout = t1_exit;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Yin     = op_alu;
            rout_en = op_alu;
         end
         S_T4: begin
            rout_en    = 1'b1;
            rout_field = ir[18:15];
            Zin        = 1'b1;
            alu_op     = alu_of_opcode(opcode);
         end
         S_T5: begin
            Zlowout = 1'b1;
            rin_en  = 1'b1;
         end
         default: ;
      endcase
   end

   cu_reg_decode u_rout (
      .field  (rout_field),
      .en     (rout_en),
      .onehot (Rout)
   );

   cu_reg_decode u_rin (
      .field  (ir[26:23]),
      .en     (rin_en),
      .onehot (Rin)
   );

   assign run     = (state_reg >= S_T0) && (state_reg <= S_T5);
   assign illegal = illegal_reg;
   assign state   = state_reg;

endmodule
